// File: rtl/bfp_scale_ctrl.sv
// Block-floating-point scaling controller: tracks per-stage minimum headroom and
// derives the next-stage right-shift and block exponent. Optional stat register: BFP_STAT_EN.
module bfp_scale_ctrl #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned N_FFT     = 64,
    parameter int unsigned N_STAGE   = 6,
    parameter int unsigned GUARD     = 2,
    parameter int unsigned MAX_SHIFT = 2,
    parameter int unsigned EXP_W     = 5,
    localparam int unsigned CW       = $clog2(WIDTH) + 1,
    localparam int unsigned SW       = $clog2(MAX_SHIFT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CW-1:0]    s_re_cnt,
    input  logic [CW-1:0]    s_im_cnt,
    output logic [SW-1:0]    shift_amt,
    output logic             shift_valid,
    output logic [EXP_W-1:0] blk_exp,
    output logic             exp_ovf,
    output logic             done,
    output logic             busy,
    output logic [CW-1:0]    stat_min_head
);

    localparam int unsigned SMP_W = $clog2(N_FFT);
    localparam int unsigned STG_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam int unsigned EXS_W = EXP_W + 1;
    localparam logic [CW-1:0]    HEAD_MAX = CW'(WIDTH - 1);
    localparam logic [EXP_W-1:0] EXP_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DECIDE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SMP_W-1:0] r_smp;
    logic [STG_W-1:0] r_stg;
    logic [CW-1:0]    r_min_head;
    logic [SW-1:0]    r_shift_amt;
    logic             r_shift_valid;
    logic [EXP_W-1:0] r_blk_exp;
    logic             r_exp_ovf;
    logic             r_done;

    logic             w_accept;
    logic             w_last_smp;
    logic             w_last_stg;
    logic [CW-1:0]    w_pair_min;
    logic [CW-1:0]    w_min_nxt;
    logic             w_below_guard;
    logic [CW-1:0]    w_deficit;
    logic [SW-1:0]    w_shift;
    logic [EXS_W-1:0] w_exp_sum;
    logic             w_exp_sat;

    assign s_ready    = (r_state == ST_SCAN);
    assign busy       = (r_state != ST_IDLE);
    assign w_accept   = s_valid && (r_state == ST_SCAN);
    assign w_last_smp = (r_smp == SMP_W'(N_FFT - 1));
    assign w_last_stg = (r_stg == STG_W'(N_STAGE - 1));

    assign w_pair_min = (s_re_cnt < s_im_cnt) ? s_re_cnt : s_im_cnt;
    assign w_min_nxt  = (w_pair_min < r_min_head) ? w_pair_min : r_min_head;

    // Shift needed to restore GUARD bits of headroom, clamped to MAX_SHIFT
    assign w_below_guard = (r_min_head < CW'(GUARD));
    assign w_deficit     = CW'(GUARD) - r_min_head;
    assign w_shift       = !w_below_guard                 ? '0 :
                           (w_deficit > CW'(MAX_SHIFT))   ? SW'(MAX_SHIFT) :
                                                            SW'(w_deficit);
    assign w_exp_sum     = {1'b0, r_blk_exp} + EXS_W'(w_shift);
    assign w_exp_sat     = (w_exp_sum > {1'b0, EXP_MAX});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_SCAN;
            ST_SCAN:   if (w_accept && w_last_smp) w_state_nxt = ST_DECIDE;
            ST_DECIDE: w_state_nxt = w_last_stg ? ST_IDLE : ST_SCAN;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp         <= '0;
            r_stg         <= '0;
            r_min_head    <= HEAD_MAX;
            r_shift_amt   <= '0;
            r_shift_valid <= 1'b0;
            r_blk_exp     <= '0;
            r_exp_ovf     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_shift_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_smp      <= '0;
                        r_stg      <= '0;
                        r_min_head <= HEAD_MAX;
                        r_blk_exp  <= '0;
                        r_exp_ovf  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_accept) begin
                        r_min_head <= w_min_nxt;
                        r_smp      <= r_smp + SMP_W'(1);
                    end
                end
                ST_DECIDE: begin
                    r_shift_amt   <= w_shift;
                    r_shift_valid <= 1'b1;
                    r_blk_exp     <= w_exp_sat ? EXP_MAX : w_exp_sum[EXP_W-1:0];
                    if (w_exp_sat) r_exp_ovf <= 1'b1;
                    r_min_head    <= HEAD_MAX;
                    r_smp         <= '0;
                    if (w_last_stg) r_done <= 1'b1;
                    else            r_stg  <= r_stg + STG_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign shift_amt   = r_shift_amt;
    assign shift_valid = r_shift_valid;
    assign blk_exp     = r_blk_exp;
    assign exp_ovf     = r_exp_ovf;
    assign done        = r_done;

`ifdef BFP_STAT_EN
    // Transform-wide minimum headroom, spanning all stages
    logic [CW-1:0] r_stat_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_min <= HEAD_MAX;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stat_min <= HEAD_MAX;
        end else if (w_accept && (w_pair_min < r_stat_min)) begin
            r_stat_min <= w_pair_min;
        end
    end

    assign stat_min_head = r_stat_min;
`else
    assign stat_min_head = HEAD_MAX;
`endif

endmodule

// File: doc/bfp_scale_ctrl.md
# bfp_scale_ctrl

Block-floating-point scaling controller for the FFT datapath. It consumes per-sample leading-sign-bit counts (headroom) from the real/imag magnitude detectors during each butterfly stage and tracks the minimum headroom over the stage. At stage end it decides the right-shift the next stage must apply and accumulates the transform's block exponent. It sits beside the FFT stage sequencer, between the detector outputs and the stage scaler.

## Interface
Parameters:
- WIDTH, 16, datapath sample width; headroom counts are CW = $clog2(WIDTH)+1 bits
- N_FFT, 64, samples per stage (frame length); must be ≥ 2
- N_STAGE, 6, stages per transform; must be ≥ 1
- GUARD, 2, required headroom bits before the next stage
- MAX_SHIFT, 2, clamp on the per-stage shift
- EXP_W, 5, block exponent width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a transform; honoured only in IDLE
- s_valid  in  1  headroom pair valid
- s_ready  out  1  controller accepts a pair; high only in SCAN
- s_re_cnt  in  CW  real-part headroom, range 0..WIDTH-1
- s_im_cnt  in  CW  imag-part headroom, range 0..WIDTH-1
- shift_amt  out  $clog2(MAX_SHIFT+1)  shift for the next stage; held until the next update
- shift_valid  out  1  one-cycle pulse when shift_amt updates
- blk_exp  out  EXP_W  accumulated block exponent; held after done until the next start
- exp_ovf  out  1  sticky; blk_exp saturated
- done  out  1  one-cycle pulse; transform complete
- busy  out  1  state != IDLE
- stat_min_head  out  CW  minimum headroom over the whole transform (see Configuration)

## Operation
- States: IDLE, SCAN, DECIDE.
- IDLE + start: clear blk_exp, exp_ovf, stage counter and sample counter; set min_head = WIDTH-1; go to SCAN.
- SCAN: a pair is accepted on s_valid && s_ready.
  - min_head ← min(min_head, s_re_cnt, s_im_cnt).
  - Sample counter increments on each accept.
  - On the N_FFT-th accept, go to DECIDE.
  - Gaps in s_valid are allowed; counters hold.
- DECIDE (exactly one cycle):
  - shift = (min_head < GUARD) ? min(GUARD − min_head, MAX_SHIFT) : 0.
  - Register shift_amt and pulse shift_valid.
  - blk_exp ← blk_exp + shift, saturating at 2^EXP_W − 1; set exp_ovf on saturation.
  - Reset min_head to WIDTH-1 and the sample counter to 0.
  - Last stage: pulse done and go to IDLE. Otherwise increment the stage counter and go to SCAN.
- start while busy is ignored.
- s_valid outside SCAN is not accepted (s_ready = 0).
- Counts above WIDTH-1 are not produced by the detectors; behaviour for such inputs is unspecified.
- rst at any point, including mid-SCAN, returns to IDLE and restores all reset values in the same edge. A partial stage is discarded.

## Timing
- Reset values:
  - state IDLE, s_ready 0, busy 0
  - shift_amt 0, shift_valid 0, done 0
  - blk_exp 0, exp_ovf 0
  - stat_min_head WIDTH-1
- s_ready and busy are combinational from state. All other outputs are registered.
- start sampled at edge e: busy and s_ready are high in the cycle after e.
- Last pair of a stage accepted in cycle t:
  - Cycle t+1: DECIDE; s_ready = 0.
  - Cycle t+2: shift_amt, shift_valid and blk_exp are updated and visible. SCAN resumes with s_ready = 1, or IDLE after the last stage with done = 1.
- A transform with no input gaps takes N_STAGE × (N_FFT + 1) cycles from the first accept to done.
- shift_valid and done coincide on the final stage.

## Configuration
- BFP_STAT_EN defined:
  - stat_min_head is a register cleared to WIDTH-1 on start.
  - It is min-updated with every accepted count across all stages and held after done.
- BFP_STAT_EN undefined: stat_min_head is tied to the constant WIDTH-1 and no stat register exists.

## Test plan
Use WIDTH=16, N_FFT=4, N_STAGE=3, GUARD=2, MAX_SHIFT=2, EXP_W=5 unless stated otherwise.
- Reset and idle: after rst, all outputs equal their reset values. s_valid=1 with start=0 keeps s_ready=0 and busy=0.
- Stage with counts {7,5,9,6}/{8,8,5,10} (min 5): shift_amt=0, shift_valid pulses at t+2, blk_exp=0.
- Stage minima 1, then 0: shift_amt=1, then 2 (GUARD−0=2 ≤ MAX_SHIFT). With MAX_SHIFT=1 and min 0, shift_amt=1 (clamped).
- Full transform, stage minima 1, 0, 4, with random s_valid gaps:
  - shifts 1, 2, 0; blk_exp=3
  - done one cycle, two cycles after the 12th accept
  - with BFP_STAT_EN, stat_min_head=0
- start asserted mid-SCAN has no effect. rst mid-SCAN (after 2 accepts) returns to IDLE with blk_exp=0. A new transform then runs cleanly.
- EXP_W=2, stage minima 0, 0, 0: blk_exp saturates at 3 and exp_ovf=1 stays set until the next start.
